ldpc_frame_ctrl: RTL and testbench

//  Frame-level sequencer for the LDPC decoder core. Accepts LLR frames over a valid/ready

---
 rtl/ldpc_pkg.sv | 20 ++
 rtl/ldpc_frame_ctrl_if.sv | 37 +++
 rtl/ldpc_frame_stage.sv | 43 ++++
 rtl/ldpc_frame_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ldpc_frame_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ldpc_pkg.sv
// -----------------------------------------------------------------------------
// ldpc_pkg
// Shared definitions for the LDPC frame sequencer: FSM state encoding and the
// default frame / result / iteration-counter widths.
// -----------------------------------------------------------------------------
package ldpc_pkg;

  localparam int DEF_FRAME_W = 11520;  // R*D*data_w = 24*96*5
  localparam int DEF_RES_W   = 2304;   // R*D hard decisions
  localparam int DEF_ITER_W  = 6;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/ldpc_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// ldpc_frame_ctrl_if
// Stream-side signals of the LDPC frame sequencer: the LLR frame input
// (valid/ready) and the decoded result output (valid/ready).
//   in_valid / in_ready / in_sig      : LLR frame stream into the staging reg
//   out_valid / out_ready / out_res   : decoded word stream
//   out_iter / out_fail               : side information for the decoded word
// Modports:
//   slave  : the sequencer (consumes frames, produces results)
//   master : the surrounding logic (produces frames, consumes results)
// -----------------------------------------------------------------------------
interface ldpc_frame_ctrl_if #(
  parameter int FRAME_W = ldpc_pkg::DEF_FRAME_W,
  parameter int RES_W   = ldpc_pkg::DEF_RES_W,
  parameter int ITER_W  = ldpc_pkg::DEF_ITER_W
) ();

  logic               in_valid;
  logic               in_ready;
  logic [FRAME_W-1:0] in_sig;
  logic               out_valid;
  logic               out_ready;
  logic [RES_W-1:0]   out_res;
  logic [ITER_W-1:0]  out_iter;
  logic               out_fail;

  modport slave (
    input  in_valid, in_sig, out_ready,
    output in_ready, out_valid, out_res, out_iter, out_fail
  );

  modport master (
    output in_valid, in_sig, out_ready,
    input  in_ready, out_valid, out_res, out_iter, out_fail
  );

endinterface

// File: rtl/ldpc_frame_stage.sv
// -----------------------------------------------------------------------------
// ldpc_frame_stage
// One-frame staging register with a valid/ready input side.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : frame offered on in_sig
//   in_sig    : LLR frame
//   in_ready  : register empty, frame will be taken
//   clr       : sequencer has started the staged frame; mark empty
//   full      : register holds a frame not yet started
//   data      : staged frame; keeps its value after clr until the next load
// -----------------------------------------------------------------------------
module ldpc_frame_stage #(
  parameter int FRAME_W = ldpc_pkg::DEF_FRAME_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [FRAME_W-1:0] in_sig,
  output logic               in_ready,
  input  logic               clr,
  output logic               full,
  output logic [FRAME_W-1:0] data
);

  assign in_ready = ~full;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of the others, independent of statement order.
  // NOTE: the data register is reset as well because core_sig must read 0
  // out of reset; it is a plain register, not a RAM, so this costs nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && !full) begin
      data <= in_sig;
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/ldpc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// ldpc_frame_ctrl
// Frame-level sequencer for the LDPC decoder core. Stages one LLR frame, loads
// it into the core with a one-cycle core_start pulse, gates core_en once per
// iteration, stops at core_term or at the programmable iteration cap, and
// captures the hard decisions into a valid/ready output register.
//   clk, rst      : clock, asynchronous active-high reset
//   bus           : ldpc_frame_ctrl_if.slave (frame in, result out)
//   cfg_max_iter  : iteration cap, sampled in START (0 means 2^ITER_W)
//   core_start    : one-cycle load pulse to the core
//   core_en       : core iteration enable
//   core_sig      : staged frame towards the core
//   core_term     : core terminated (converged or internal limit)
//   core_res      : core latched result (used on core_term)
//   core_dec      : core live decisions (used when the cap is reached)
//   stat_frames   : frames completed
//   stat_fails    : frames terminated by the cap
// Build option: define LDPC_STATS_EN to get saturating statistics counters;
// without it stat_frames / stat_fails are constant 0.
// -----------------------------------------------------------------------------
module ldpc_frame_ctrl
  import ldpc_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int ITER_W  = DEF_ITER_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  ldpc_frame_ctrl_if.slave   bus,
  input  logic [ITER_W-1:0]  cfg_max_iter,
  output logic               core_start,
  output logic               core_en,
  output logic [FRAME_W-1:0] core_sig,
  input  logic               core_term,
  input  logic [RES_W-1:0]   core_res,
  input  logic [RES_W-1:0]   core_dec,
  output logic [CNT_W-1:0]   stat_frames,
  output logic [CNT_W-1:0]   stat_fails
);

  state_t            state, state_nx;
  logic [ITER_W-1:0] iter;
  logic [ITER_W:0]   cap;       // one extra bit so a cap of 2^ITER_W fits
  logic [ITER_W:0]   iter_inc;
  logic              cap_hit;
  logic              hold_fail; // capture reason remembered across HOLD
  logic              stg_full;
  logic              stg_clr;
  logic              out_block;
  logic              do_capture;
  logic              cap_fail;
  logic              go_hold;

  logic              out_valid_q;
  logic [RES_W-1:0]  out_res_q;
  logic [ITER_W-1:0] out_iter_q;
  logic              out_fail_q;

  ldpc_frame_stage #(.FRAME_W(FRAME_W)) u_stage (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_sig   (bus.in_sig),
    .in_ready (bus.in_ready),
    .clr      (stg_clr),
    .full     (stg_full),
    .data     (core_sig)
  );

  assign iter_inc  = {1'b0, iter} + {{ITER_W{1'b0}}, 1'b1};
  assign cap_hit   = (iter_inc == cap);
  // Output register occupied and not being drained this cycle.
  assign out_block = out_valid_q && !bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    core_start = 1'b0;
    core_en    = 1'b0;
    stg_clr    = 1'b0;
    do_capture = 1'b0;
    cap_fail   = 1'b0;
    go_hold    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (stg_full) state_nx = ST_START;
      end
      ST_START: begin
        core_start = 1'b1;
        stg_clr    = 1'b1;
        state_nx   = ST_RUN;
      end
      ST_RUN: begin
        if (core_term || cap_hit) begin
          // core_en drops in the terminating cycle itself.
          if (out_block) begin
            go_hold  = 1'b1;
            state_nx = ST_HOLD;
          end else begin
            do_capture = 1'b1;
            cap_fail   = !core_term;
            state_nx   = stg_full ? ST_START : ST_IDLE;
          end
        end else begin
          core_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!out_block) begin
          do_capture = 1'b1;
          cap_fail   = hold_fail;
          state_nx   = stg_full ? ST_START : ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Iteration counter and cap; iter only advances on real core iterations,
  // so it stays frozen while waiting in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter      <= '0;
      cap       <= '0;
      hold_fail <= 1'b0;
    end else begin
      if (state == ST_START) begin
        iter <= '0;
        cap  <= (cfg_max_iter == '0) ? {1'b1, {ITER_W{1'b0}}}
                                     : {1'b0, cfg_max_iter};
      end else if (core_en) begin
        iter <= iter_inc[ITER_W-1:0];
      end
      if (go_hold) hold_fail <= !core_term;
    end
  end

  // Output register. A capture wins over a drain, so capture+drain in the
  // same cycle leaves out_valid set with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_iter_q  <= '0;
      out_fail_q  <= 1'b0;
    end else if (do_capture) begin
      out_valid_q <= 1'b1;
      out_res_q   <= cap_fail ? core_dec : core_res;
      // iter+1 can reach 2^ITER_W only with the maximum cap; saturate it.
      out_iter_q  <= iter_inc[ITER_W] ? {ITER_W{1'b1}} : iter_inc[ITER_W-1:0];
      out_fail_q  <= cap_fail;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_iter  = out_iter_q;
  assign bus.out_fail  = out_fail_q;

`ifdef LDPC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] frames_q;
  logic [CNT_W-1:0] fails_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_q <= '0;
      fails_q  <= '0;
    end else if (do_capture) begin
      if (frames_q != {CNT_W{1'b1}})             frames_q <= frames_q + CNT_ONE;
      if (cap_fail && fails_q != {CNT_W{1'b1}})  fails_q  <= fails_q + CNT_ONE;
    end
  end

  assign stat_frames = frames_q;
  assign stat_fails  = fails_q;
`else
  assign stat_frames = '0;
  assign stat_fails  = '0;
`endif

endmodule

// File: tb/tb_ldpc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ldpc_frame_ctrl
// Bench for ldpc_frame_ctrl with reduced frame/result widths. A small core
// model latches the frame on core_start; frame[15:8] is the iteration at which
// the model converges (0 = never) and frame[7:0] a payload from which the
// core result (payload^A5) and live decisions (payload^3C) are formed.
// -----------------------------------------------------------------------------
module tb_ldpc_frame_ctrl;
  import ldpc_pkg::*;

  localparam int FW = 16;
  localparam int RW = 8;
  localparam int IW = 6;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] cfg_max_iter;
  logic          core_start, core_en, core_term;
  logic [FW-1:0] core_sig;
  logic [RW-1:0] core_res, core_dec;
  logic [CW-1:0] stat_frames, stat_fails;

  always #5 clk = ~clk;

  ldpc_frame_ctrl_if #(.FRAME_W(FW), .RES_W(RW), .ITER_W(IW)) bus ();

  ldpc_frame_ctrl #(.FRAME_W(FW), .RES_W(RW), .ITER_W(IW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .cfg_max_iter (cfg_max_iter),
    .core_start   (core_start),
    .core_en      (core_en),
    .core_sig     (core_sig),
    .core_term    (core_term),
    .core_res     (core_res),
    .core_dec     (core_dec),
    .stat_frames  (stat_frames),
    .stat_fails   (stat_fails)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- core model ----------------
  logic [FW-1:0] frame_q;
  int            en_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      en_cnt  <= 0;
    end else if (core_start) begin
      frame_q <= core_sig;
      en_cnt  <= 0;
    end else if (core_en) begin
      en_cnt  <= en_cnt + 1;
    end
  end

  always_comb begin
    core_term = (frame_q[15:8] != 8'd0) && (en_cnt == int'(frame_q[15:8]) - 1);
    core_res  = frame_q[7:0] ^ 8'hA5;
    core_dec  = frame_q[7:0] ^ 8'h3C;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [RW-1:0] res;
    logic [IW-1:0] iter;
    logic          fail;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   frames_done = 0;
  int   fails_done  = 0;

  function automatic exp_t model(input logic [FW-1:0] f, input logic [IW-1:0] cfg);
    exp_t e;
    int   cap, conv, it;
    cap  = (cfg == '0) ? 64 : int'(cfg);
    conv = int'(f[15:8]);
    if (conv != 0 && conv <= cap) begin
      e.res  = f[7:0] ^ 8'hA5;
      e.fail = 1'b0;
      it     = conv;
    end else begin
      e.res  = f[7:0] ^ 8'h3C;
      e.fail = 1'b1;
      it     = cap;
    end
    e.iter = (it > 63) ? '1 : IW'(it);
    return e;
  endfunction

  // Output monitor: each accepted result is compared with the oldest
  // expectation; a result with nothing expected is itself an error.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_res",  64'(bus.out_res),  64'(mon_e.res));
        check("out_iter", 64'(bus.out_iter), 64'(mon_e.iter));
        check("out_fail", 64'(bus.out_fail), 64'(mon_e.fail));
        frames_done++;
        if (mon_e.fail) fails_done++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [FW-1:0] f);
    bit ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sig   = f;
    for (int t = 0; t < 200 && !ok; t++) begin
      ok = bus.in_ready;
      if (ok) sb.push_back(model(f, cfg_max_iter));
      tick();
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic wait_start(output int c);
    c = 0;
    while (!core_start && c < 100) begin
      tick();
      c++;
    end
    if (!core_start) check("start_timeout", {63'd0, core_start}, 64'd1);
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!bus.out_valid && c < 300) begin
      tick();
      c++;
    end
    if (!bus.out_valid) check("valid_timeout", {63'd0, bus.out_valid}, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    sb.delete();
    frames_done = 0;
    fails_done  = 0;
    rst = 1'b0;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]    conv;
    logic [7:0]    pay;
    logic [IW-1:0] cfg;
    int            exp_iter;
    bit            exp_fail;
    int            exp_en;
  } vec_t;

  vec_t tbl[8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   c, lat;
    int   seen;
    exp_t ea;

    tbl[0] = '{8'd3,  8'h11, 6'd10, 3,  1'b0, 2};   // converges at 3
    tbl[1] = '{8'd0,  8'h22, 6'd5,  5,  1'b1, 4};   // cap of 5 reached
    tbl[2] = '{8'd0,  8'h33, 6'd1,  1,  1'b1, 0};   // minimum cap
    tbl[3] = '{8'd4,  8'h44, 6'd4,  4,  1'b0, 3};   // term and cap together
    tbl[4] = '{8'd9,  8'h55, 6'd4,  4,  1'b1, 3};   // cap before convergence
    tbl[5] = '{8'd0,  8'h66, 6'd0,  63, 1'b1, 63};  // cap 64, iter saturates
    tbl[6] = '{8'd1,  8'h77, 6'd63, 1,  1'b0, 0};   // converges immediately
    tbl[7] = '{8'd64, 8'h88, 6'd0,  63, 1'b0, 63};  // converges on 64th, saturates

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sig    = '0;
    bus.out_ready = 1'b1;
    cfg_max_iter  = 6'd10;
    #12;

    // Reset state
    check("rst_in_ready",   64'(bus.in_ready),  64'd1);
    check("rst_out_valid",  64'(bus.out_valid), 64'd0);
    check("rst_out_res",    64'(bus.out_res),   64'd0);
    check("rst_out_iter",   64'(bus.out_iter),  64'd0);
    check("rst_out_fail",   64'(bus.out_fail),  64'd0);
    check("rst_core_start", 64'(core_start),    64'd0);
    check("rst_core_en",    64'(core_en),       64'd0);
    check("rst_core_sig",   64'(core_sig),      64'd0);
    check("rst_stat_frames", 64'(stat_frames),  64'd0);
    do_reset();

    // Table-driven single frames
    for (int i = 0; i < 8; i++) begin
      bus.out_ready = 1'b1;
      cfg_max_iter  = tbl[i].cfg;
      send({tbl[i].conv, tbl[i].pay});
      wait_start(c);
      check($sformatf("v%0d_start_lat", i), 64'(c), 64'd1);
      check($sformatf("v%0d_core_sig", i), 64'(core_sig), 64'({tbl[i].conv, tbl[i].pay}));
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(tbl[i].exp_en + 2));
      check($sformatf("v%0d_iter", i), 64'(bus.out_iter), 64'(tbl[i].exp_iter));
      check($sformatf("v%0d_fail", i), 64'(bus.out_fail), 64'(tbl[i].exp_fail));
      check($sformatf("v%0d_en_cycles", i), 64'(en_cnt), 64'(tbl[i].exp_en));
      check($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
      tick();
      check($sformatf("v%0d_drained", i), 64'(bus.out_valid), 64'd0);
    end

    // Back-to-back: B staged during A's RUN, started right after A's capture
    cfg_max_iter = 6'd10;
    send({8'd4, 8'hA1});
    wait_start(c);
    tick();
    send({8'd2, 8'hB2});
    check("b2b_staged_in_ready", 64'(bus.in_ready), 64'd0);
    wait_valid(lat);
    check("b2b_a_res", 64'(bus.out_res), 64'(8'hA1 ^ 8'hA5));
    check("b2b_b_start", 64'(core_start), 64'd1);
    tick();
    wait_valid(lat);
    check("b2b_b_res", 64'(bus.out_res), 64'(8'hB2 ^ 8'hA5));
    tick();
    check("b2b_sb_empty", 64'(sb.size()), 64'd0);

    // HOLD: output full and not draining when the second frame converges
    bus.out_ready = 1'b0;
    send({8'd2, 8'hAB});
    wait_valid(lat);
    send({8'd2, 8'hCD});
    wait_start(c);
    repeat (5) tick();
    check("hold_core_en",   64'(core_en),       64'd0);
    check("hold_en_cycles", 64'(en_cnt),        64'd1);
    check("hold_out_valid", 64'(bus.out_valid), 64'd1);
    check("hold_out_res",   64'(bus.out_res),   64'(8'hAB ^ 8'hA5));
    bus.out_ready = 1'b1;
    tick();
    check("hold_keep_valid", 64'(bus.out_valid), 64'd1);
    check("hold_new_res",    64'(bus.out_res),    64'(8'hCD ^ 8'hA5));
    check("hold_new_iter",   64'(bus.out_iter),   64'd2);
    tick();
    check("hold_drained", 64'(bus.out_valid), 64'd0);
    check("hold_sb_empty", 64'(sb.size()), 64'd0);

`ifdef LDPC_STATS_EN
    check("stat_frames_mid", 64'(stat_frames), 64'(frames_done));
    check("stat_fails_mid",  64'(stat_fails),  64'(fails_done));
`else
    check("stat_frames_off", 64'(stat_frames), 64'd0);
    check("stat_fails_off",  64'(stat_fails),  64'd0);
`endif

    // Reset mid-RUN with a held result and a frame at iteration 2
    bus.out_ready = 1'b0;
    cfg_max_iter  = 6'd10;
    send({8'd2, 8'h5A});
    wait_valid(lat);
    send({8'd0, 8'h6B});
    wait_start(c);
    c = 0;
    while (en_cnt < 2 && c < 50) begin
      tick();
      c++;
    end
    check("rst_reach_iter2", 64'(en_cnt), 64'd2);
    rst = 1'b1;
    #1;
    check("arst_out_valid",  64'(bus.out_valid), 64'd0);
    check("arst_core_en",    64'(core_en),       64'd0);
    check("arst_core_start", 64'(core_start),    64'd0);
    check("arst_in_ready",   64'(bus.in_ready),  64'd1);
    check("arst_core_sig",   64'(core_sig),      64'd0);
    check("arst_out_res",    64'(bus.out_res),   64'd0);
    check("arst_stat",       64'(stat_frames),   64'd0);
    sb.delete();
    frames_done = 0;
    fails_done  = 0;
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (bus.out_valid || core_start) seen++;
    end
    check("no_activity_after_rst", 64'(seen), 64'd0);

    // Recovery: a capped frame after reset
    cfg_max_iter = 6'd5;
    ea = model({8'd0, 8'h7E}, 6'd5);
    send({8'd0, 8'h7E});
    wait_start(c);
    wait_valid(lat);
    check("rec_res",  64'(bus.out_res),  64'(ea.res));
    check("rec_iter", 64'(bus.out_iter), 64'd5);
    check("rec_fail", 64'(bus.out_fail), 64'd1);
    tick();
    tick();
    check("final_sb_empty", 64'(sb.size()), 64'd0);
`ifdef LDPC_STATS_EN
    check("stat_frames_end", 64'(stat_frames), 64'd1);
    check("stat_fails_end",  64'(stat_fails),  64'd1);
`else
    check("stat_frames_end", 64'(stat_frames), 64'd0);
    check("stat_fails_end",  64'(stat_fails),  64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
